// File: rtl/bin_to_bcd_seq_pkg.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - state_e   : FSM state encoding (IDLE, SHIFT, DONE)
//   - BCD_W     : width of one BCD digit
//   - BLANK     : digit code the 7-segment decoder renders as all segments off
//   - calc_sd() : number of scratch digits needed to hold 2^width-1
// ---------------------------------------------------------------------------
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int         BCD_W = 4;
  localparam logic [3:0] BLANK = 4'hF;

  // Each decimal digit covers a bit more than 3 binary bits, so
  // ceil(width/3) digits always hold 2^width-1.
  function automatic int calc_sd(input int width);
    return (width + 2) / 3;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq_if
// Start/done handshake and data bus of the converter.
//   start : conversion request (master -> slave)
//   bin   : unsigned binary value, WIDTH bits (master -> slave)
//   busy  : conversion in progress (slave -> master)
//   done  : one-cycle result strobe (slave -> master)
//   bcd   : DIGITS packed BCD digits, digit 0 = units (slave -> master)
//   ovf   : last result did not fit in DIGITS digits (slave -> master)
// ---------------------------------------------------------------------------
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
);

  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);

endinterface

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more so that
// the following left shift carries correctly into the next decimal digit.
//   i_digit : scratch digit before correction
//   o_digit : corrected digit
// ---------------------------------------------------------------------------
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [BCD_W-1:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3). One conversion takes
// WIDTH shift cycles after the accepting edge; done pulses for one cycle in
// the DONE state. Values above 10^DIGITS-1 set ovf and blank every digit.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : bin_to_bcd_seq_if slave (start, bin -> busy, done, bcd, ovf)
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  bin_to_bcd_seq_if.slave   bus
);

  localparam int SD    = calc_sd(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);
  // Scratch result zero-extended to at least DIGITS digits, so digit
  // selection and the overflow test need no per-parameter special cases.
  localparam int PAD_D = (SD > DIGITS) ? SD : DIGITS;

  state_e                     r_state;
  state_e                     w_state_nxt;
  logic [WIDTH-1:0]           r_shift;
  logic [BCD_W*SD-1:0]        r_scratch;
  logic [BCD_W*SD-1:0]        w_corr;
  logic [CNT_W-1:0]           r_cnt;
  logic [BCD_W*DIGITS-1:0]    r_bcd;
  logic                       r_ovf;
  logic [BCD_W*DIGITS-1:0]    w_bcd_res;
  logic                       w_ovf_res;
  logic                       w_accept;
  logic                       w_last;
  logic [BCD_W*SD+WIDTH-1:0]  w_shifted;
  logic [BCD_W*PAD_D-1:0]     w_pad;

  // Add-3 correction on every scratch digit before the shift.
  for (genvar g = 0; g < SD; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_scratch[BCD_W*g +: BCD_W]),
      .o_digit (w_corr[BCD_W*g +: BCD_W])
    );
  end

  // start is honoured only while idle or presenting a result; in SHIFT it
  // is dropped, not queued.
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // r_cnt counts shifts already done, so the WIDTH-th shift is at WIDTH-1.
  assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

  // {scratch, shift} moves left as one register; the shift MSB enters
  // scratch digit 0.
  assign w_shifted = {w_corr, r_shift} << 1;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_pad                  = '0;
    w_pad[BCD_W*SD-1:0]    = w_shifted[BCD_W*SD+WIDTH-1:WIDTH];
    w_ovf_res              = |(w_pad >> (BCD_W*DIGITS));
    w_bcd_res              = w_ovf_res ? {DIGITS{BLANK}} : w_pad[BCD_W*DIGITS-1:0];
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = bus.start ? ST_SHIFT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Datapath: shift/scratch/counter and the held result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift   <= bus.bin;
        r_scratch <= '0;
        r_cnt     <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_shift   <= w_shifted[WIDTH-1:0];
        r_scratch <= w_shifted[BCD_W*SD+WIDTH-1:WIDTH];
        r_cnt     <= r_cnt + CNT_W'(1);
      end
      // Result registers change only on the SHIFT->DONE edge and hold
      // their value between conversions.
      if (w_last) begin
        r_bcd <= w_bcd_res;
        r_ovf <= w_ovf_res;
      end
    end
  end

  // Outputs are registers or decodes of the state register only.
  assign bus.busy = (r_state == ST_SHIFT);
  assign bus.done = (r_state == ST_DONE);
  assign bus.bcd  = r_bcd;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq. Two instances: WIDTH=6 (no
// overflow possible) and WIDTH=7 (overflow above 99), both DIGITS=2.
// Stimulus pushes the expected result (from /10 and %10 arithmetic) into a
// per-instance queue; a negedge monitor pops and compares on every done.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n;

  initial forever #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(6), .DIGITS(2)) if6 ();
  bin_to_bcd_seq_if #(.WIDTH(7), .DIGITS(2)) if7 ();

  bin_to_bcd_seq #(.WIDTH(6), .DIGITS(2)) dut6 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if6)
  );

  bin_to_bcd_seq #(.WIDTH(7), .DIGITS(2)) dut7 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if7)
  );

  typedef struct {
    logic [7:0] bcd;
    logic       ovf;
    int         acc;   // cycle number of the accepting edge
  } exp_t;

  exp_t q6[$];
  exp_t q7[$];
  int   dcyc6[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   st6 = 0, st7 = 0, dn6 = 0, dn7 = 0;
  int   busy6 = 0, busy7 = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event (t=%0t)", name, $time);
  endtask

  // Reference model: two decimal digits, blanked with ovf above 99.
  function automatic exp_t model(input int v, input int acc);
    exp_t e;
    e.acc = acc;
    if (v > 99) begin
      e.bcd = 8'hFF;
      e.ovf = 1'b1;
    end else begin
      e.bcd = {4'(v / 10), 4'(v % 10)};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 6) ? if6.busy : if7.busy;
  endfunction

  task automatic drive(input int sel, input logic s, input int v);
    if (sel == 6) begin
      if6.start = s;
      if6.bin   = 6'(v);
    end else begin
      if7.start = s;
      if7.bin   = 7'(v);
    end
  endtask

  // Returns #1 after a rising edge with the instance in IDLE or DONE.
  task automatic wait_idle(input int sel);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy_of(sel) && n < 100);
    if (busy_of(sel)) fail_timeout($sformatf("dut%0d_wait_idle", sel));
  endtask

  task automatic convert(input int sel, input int v);
    wait_idle(sel);
    drive(sel, 1'b1, v);
    if (sel == 6) begin
      q6.push_back(model(v, cyc + 1));
      st6++;
    end else begin
      q7.push_back(model(v, cyc + 1));
      st7++;
    end
    @(posedge clk);
    #1;
    // Scramble bin after capture; it must not affect the result.
    drive(sel, 1'b0, int'($urandom));
  endtask

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy6 = 0;
        busy7 = 0;
      end else begin
        if (if6.busy) busy6++;
        if (if7.busy) busy7++;
        if (if6.done) begin
          dn6++;
          dcyc6.push_back(cyc);
          if (q6.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut6_unexpected_done actual=done bcd=%h expected=no_done", if6.bcd);
          end else begin
            e = q6.pop_front();
            check("dut6_bcd",         32'(if6.bcd),    32'(e.bcd));
            check("dut6_ovf",         32'(if6.ovf),    32'(e.ovf));
            check("dut6_latency",     32'(cyc - e.acc), 32'd6);
            check("dut6_busy_cycles", 32'(busy6),      32'd6);
          end
          busy6 = 0;
        end
        if (if7.done) begin
          dn7++;
          if (q7.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut7_unexpected_done actual=done bcd=%h expected=no_done", if7.bcd);
          end else begin
            e = q7.pop_front();
            check("dut7_bcd",         32'(if7.bcd),    32'(e.bcd));
            check("dut7_ovf",         32'(if7.ovf),    32'(e.ovf));
            check("dut7_latency",     32'(cyc - e.acc), 32'd7);
            check("dut7_busy_cycles", 32'(busy7),      32'd7);
          end
          busy7 = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    int   idx, n, d0, tmp, j;
    int   vals[64];
    exp_t e42;

    rst_n = 1'b0;
    drive(6, 1'b0, 0);
    drive(7, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_dut6_busy", 32'(if6.busy), 32'd0);
    check("rst_dut6_done", 32'(if6.done), 32'd0);
    check("rst_dut6_bcd",  32'(if6.bcd),  32'd0);
    check("rst_dut7_ovf",  32'(if7.ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single conversion of 63.
    convert(6, 63);

    // Back-to-back 0 then 9 with start held high.
    wait_idle(6);
    idx = dcyc6.size();
    drive(6, 1'b1, 0);
    q6.push_back(model(0, cyc + 1));
    st6++;
    @(posedge clk);
    #1;
    drive(6, 1'b1, 9);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!if6.done && n < 50);
    if (!if6.done) fail_timeout("dut6_b2b_first_done");
    q6.push_back(model(9, cyc + 1));
    st6++;
    @(posedge clk);
    #1;
    drive(6, 1'b0, 0);
    wait_idle(6);
    @(negedge clk);
    #1;
    if (dcyc6.size() >= idx + 2)
      check("dut6_b2b_gap", 32'(dcyc6[idx+1] - dcyc6[idx]), 32'd7);
    else
      fail_timeout("dut6_b2b_second_done");

    // start and a new bin mid-SHIFT are ignored.
    d0 = dn6;
    e42 = model(42, 0);
    convert(6, 42);
    repeat (3) @(posedge clk);
    #1;
    drive(6, 1'b1, 17);
    @(posedge clk);
    #1;
    drive(6, 1'b0, 17);
    wait_idle(6);
    repeat (20) @(posedge clk);
    #1;
    check("dut6_midshift_bcd",   32'(if6.bcd),  32'(e42.bcd));
    check("dut6_midshift_dones", 32'(dn6 - d0), 32'd1);

    // Asynchronous reset during the third cycle of a conversion.
    convert(6, 55);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(if6.busy), 32'd0);
    check("async_rst_done", 32'(if6.done), 32'd0);
    check("async_rst_bcd",  32'(if6.bcd),  32'd0);
    check("async_rst_ovf",  32'(if6.ovf),  32'd0);
    st6 = st6 - q6.size();
    q6.delete();
    @(negedge clk);
    rst_n = 1'b1;
    convert(6, 55);

    // Every 6-bit value in shuffled order, with random idle gaps.
    for (int i = 0; i < 64; i++) vals[i] = i;
    for (int i = 63; i > 0; i--) begin
      j       = int'($urandom_range(0, i));
      tmp     = vals[i];
      vals[i] = vals[j];
      vals[j] = tmp;
    end
    for (int i = 0; i < 64; i++) begin
      convert(6, vals[i]);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    // WIDTH=7: limits around the two-digit range, then random values.
    convert(7, 99);
    convert(7, 127);
    convert(7, 100);
    for (int i = 0; i < 24; i++) convert(7, int'($urandom_range(0, 127)));

    wait_idle(6);
    wait_idle(7);
    repeat (3) @(posedge clk);
    #1;
    check("dut6_pending",    32'(q6.size()), 32'd0);
    check("dut7_pending",    32'(q7.size()), 32'd0);
    check("dut6_done_count", 32'(dn6),       32'(st6));
    check("dut7_done_count", 32'(dn7),       32'(st7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
